// File: rtl/link_scheduler_if.sv
// link_scheduler_if: request/credit/grant bundle of one router output link.
//   slave  modport: the scheduler (takes requests and credits, drives grant/status).
//   master modport: the requester/receiver side that drives requests and credits.
//   request_vector  per-port packet request (0=XPOS 1=XNEG 2=YPOS 3=YNEG 4=PE)
//   credit_in       one-cycle credit return pulse from downstream
//   grant_vector    one-hot grant, zero when no packet is in flight
//   flit_valid      a granted flit crosses the link this cycle
//   packet_done     pulse on the last flit of a packet
//   credit_count    packet credits currently available
//   credit_overflow sticky flag: credit returned while already full
interface link_scheduler_if #(
    parameter int CNT_W = 3
);
    logic [4:0]       request_vector;
    logic             credit_in;
    logic [4:0]       grant_vector;
    logic             flit_valid;
    logic             packet_done;
    logic [CNT_W-1:0] credit_count;
    logic             credit_overflow;

    modport slave (
        input  request_vector, credit_in,
        output grant_vector, flit_valid, packet_done, credit_count, credit_overflow
    );

    modport master (
        output request_vector, credit_in,
        input  grant_vector, flit_valid, packet_done, credit_count, credit_overflow
    );
endinterface

// File: rtl/link_scheduler.sv
// link_scheduler: round-robin output-link scheduler with packet-level credits.
//   clk    system clock, all state changes on posedge
//   reset  asynchronous active-high reset
//   link   link_scheduler_if.slave: requests/credit_in in, grant and status out
// A packet holds the grant for FLITS cycles; one credit is consumed when the
// grant is issued and one is returned per credit_in pulse.
module link_scheduler #(
    parameter int CREDITS = 4,
    parameter int FLITS   = 5,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    link_scheduler_if.slave  link
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic [4:0]       grant_q, grant_d;
    logic             flit_valid_q, flit_valid_d;
    logic             packet_done_q, packet_done_d;
    logic [CNT_W-1:0] flit_cnt_q, flit_cnt_d;
    logic [CNT_W-1:0] credit_q, credit_d;
    logic             overflow_q, overflow_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       winner_q, winner_d;

    logic             found;
    logic [2:0]       pick;
    logic [3:0]       scan;
    logic             consume;

    // Round-robin pick: first requester at or above the pointer, wrapping 4->0.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        scan  = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            scan = {1'b0, ptr_q} + 4'(i);
            if (scan >= 4'd5) begin
                scan = scan - 4'd5;
            end
            if (!found && link.request_vector[scan[2:0]]) begin
                found = 1'b1;
                pick  = scan[2:0];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        flit_valid_d  = flit_valid_q;
        packet_done_d = packet_done_q;
        flit_cnt_d    = flit_cnt_q;
        ptr_d         = ptr_q;
        winner_d      = winner_q;
        consume       = 1'b0;

        case (state_q)
            IDLE: begin
                packet_done_d = 1'b0;
                if (found && (credit_q != '0)) begin
                    state_d       = ACTIVE;
                    grant_d       = 5'(1) << pick;
                    flit_valid_d  = 1'b1;
                    flit_cnt_d    = '0;
                    winner_d      = pick;
                    consume       = 1'b1;
                    packet_done_d = (FLITS == 1);
                end
            end
            ACTIVE: begin
                if (flit_cnt_q == CNT_W'(FLITS - 1)) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    flit_valid_d  = 1'b0;
                    packet_done_d = 1'b0;
                    ptr_d         = (winner_q == 3'd4) ? 3'd0 : winner_q + 3'd1;
                end else begin
                    flit_cnt_d    = flit_cnt_q + CNT_W'(1);
                    // Registered: raise done for the cycle where the counter reaches FLITS-1.
                    packet_done_d = (flit_cnt_q == CNT_W'(FLITS - 2));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Credit counter: consume and return on the same edge cancel out; a
    // return with no consume while full saturates and raises the sticky flag.
    always_comb begin
        credit_d   = credit_q;
        overflow_d = overflow_q;
        if (consume && !link.credit_in) begin
            credit_d = credit_q - CNT_W'(1);
        end else if (!consume && link.credit_in) begin
            if (credit_q == CNT_W'(CREDITS)) begin
                overflow_d = 1'b1;
            end else begin
                credit_d = credit_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            flit_valid_q  <= 1'b0;
            packet_done_q <= 1'b0;
            flit_cnt_q    <= '0;
            credit_q      <= CNT_W'(CREDITS);
            overflow_q    <= 1'b0;
            ptr_q         <= '0;
            winner_q      <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            flit_valid_q  <= flit_valid_d;
            packet_done_q <= packet_done_d;
            flit_cnt_q    <= flit_cnt_d;
            credit_q      <= credit_d;
            overflow_q    <= overflow_d;
            ptr_q         <= ptr_d;
            winner_q      <= winner_d;
        end
    end

    assign link.grant_vector    = grant_q;
    assign link.flit_valid      = flit_valid_q;
    assign link.packet_done     = packet_done_q;
    assign link.credit_count    = credit_q;
    assign link.credit_overflow = overflow_q;

endmodule

// File: tb/tb_link_scheduler.sv
// tb_link_scheduler: directed bench for link_scheduler (CREDITS=4, FLITS=5).
module tb_link_scheduler;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    link_scheduler_if #(.CNT_W(3)) link();

    link_scheduler #(
        .CREDITS (4),
        .FLITS   (5),
        .CNT_W   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .link  (link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Waits (bounded) for a grant, then checks all five flits and the idle gap.
    // Ends on the negedge of the gap cycle.
    task automatic expect_packet(input string tag, input logic [4:0] exp_g, input int exp_wait);
        int waited;
        waited = 0;
        while (link.grant_vector == 5'b0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_eq({tag, "_latency"}, 32'(waited), 32'(exp_wait));
        for (int k = 0; k < 5; k++) begin
            check_eq({tag, "_grant"}, 32'(link.grant_vector), 32'(exp_g));
            check_eq({tag, "_valid"}, 32'(link.flit_valid), 32'd1);
            check_eq({tag, "_done"}, 32'(link.packet_done), (k == 4) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        check_eq({tag, "_gap_grant"}, 32'(link.grant_vector), 32'd0);
        check_eq({tag, "_gap_valid"}, 32'(link.flit_valid), 32'd0);
        check_eq({tag, "_gap_done"}, 32'(link.packet_done), 32'd0);
    endtask

    task automatic pulse_credit();
        link.credit_in = 1'b1;
        @(negedge clk);
        link.credit_in = 1'b0;
    endtask

    task automatic apply_reset(input logic [4:0] req);
        reset = 1'b1;
        link.request_vector = req;
        link.credit_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w;
        logic saw;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        link.request_vector = 5'b0;
        link.credit_in = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check_eq("rst_grant", 32'(link.grant_vector), 32'd0);
        check_eq("rst_valid", 32'(link.flit_valid), 32'd0);
        check_eq("rst_done", 32'(link.packet_done), 32'd0);
        check_eq("rst_credit", 32'(link.credit_count), 32'd4);
        check_eq("rst_ovf", 32'(link.credit_overflow), 32'd0);

        // Single requester: one-cycle latency, 5 flits, credit 4->3
        apply_reset(5'b00001);
        expect_packet("t1", 5'b00001, 1);
        link.request_vector = 5'b0;
        check_eq("t1_credit", 32'(link.credit_count), 32'd3);
        @(negedge clk);
        check_eq("t1_idle", 32'(link.grant_vector), 32'd0);

        // Round robin over 10101 with a credit returned after each packet
        apply_reset(5'b10101);
        expect_packet("t2a", 5'b00001, 1);
        pulse_credit();
        check_eq("t2_credit_a", 32'(link.credit_count), 32'd3);
        expect_packet("t2b", 5'b00100, 0);
        pulse_credit();
        expect_packet("t2c", 5'b10000, 0);
        pulse_credit();
        link.request_vector = 5'b0;
        check_eq("t2_credit_c", 32'(link.credit_count), 32'd3);
        expect_packet("t2d", 5'b00001, 0);
        pulse_credit();
        check_eq("t2_credit_end", 32'(link.credit_count), 32'd4);
        check_eq("t2_end_grant", 32'(link.grant_vector), 32'd0);

        // All ports requesting, no credits returned: four packets then stall
        apply_reset(5'b11111);
        expect_packet("t3a", 5'b00001, 1);
        expect_packet("t3b", 5'b00010, 1);
        expect_packet("t3c", 5'b00100, 1);
        expect_packet("t3d", 5'b01000, 1);
        check_eq("t3_credit0", 32'(link.credit_count), 32'd0);
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (link.grant_vector != 5'b0) saw = 1'b1;
        end
        check_eq("t3_no_grant", 32'(saw), 32'd0);
        pulse_credit();
        check_eq("t3_credit_edge_grant", 32'(link.grant_vector), 32'd0);
        check_eq("t3_credit1", 32'(link.credit_count), 32'd1);
        expect_packet("t3e", 5'b10000, 1);
        check_eq("t3_credit_after_pe", 32'(link.credit_count), 32'd0);
        link.request_vector = 5'b0;

        // Simultaneous consume and return at count 2, then overflow at full
        pulse_credit();
        pulse_credit();
        check_eq("t4_credit2", 32'(link.credit_count), 32'd2);
        link.request_vector = 5'b00100;
        link.credit_in = 1'b1;
        @(negedge clk);
        link.credit_in = 1'b0;
        link.request_vector = 5'b0;
        check_eq("t4_grant", 32'(link.grant_vector), 32'd4);
        check_eq("t4_credit_net0", 32'(link.credit_count), 32'd2);
        expect_packet("t4", 5'b00100, 0);
        pulse_credit();
        pulse_credit();
        check_eq("t4_credit_full", 32'(link.credit_count), 32'd4);
        check_eq("t4_ovf_clear", 32'(link.credit_overflow), 32'd0);
        pulse_credit();
        check_eq("t4_credit_sat", 32'(link.credit_count), 32'd4);
        check_eq("t4_ovf_set", 32'(link.credit_overflow), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("t4_ovf_sticky", 32'(link.credit_overflow), 32'd1);

        // Reset mid-packet aborts it and restores credits and pointer
        link.request_vector = 5'b00100;
        expect_packet("t5a", 5'b00100, 1);
        link.request_vector = 5'b01000;
        @(negedge clk);
        check_eq("t5_flit1", 32'(link.grant_vector), 32'd8);
        @(negedge clk);
        @(negedge clk);
        check_eq("t5_flit3", 32'(link.grant_vector), 32'd8);
        check_eq("t5_credit_pre", 32'(link.credit_count), 32'd2);
        reset = 1'b1;
        #1;
        check_eq("t5_rst_grant", 32'(link.grant_vector), 32'd0);
        check_eq("t5_rst_valid", 32'(link.flit_valid), 32'd0);
        check_eq("t5_rst_done", 32'(link.packet_done), 32'd0);
        check_eq("t5_rst_credit", 32'(link.credit_count), 32'd4);
        check_eq("t5_rst_ovf", 32'(link.credit_overflow), 32'd0);
        link.request_vector = 5'b01010;
        @(negedge clk);
        reset = 1'b0;
        expect_packet("t5b", 5'b00010, 1);
        link.request_vector = 5'b0;

        // Granted port drops its request after flit 1; packet still full length
        link.request_vector = 5'b00011;
        w = 0;
        while (link.grant_vector == 5'b0 && w < 5) begin
            @(negedge clk);
            w++;
        end
        link.request_vector = 5'b00010;
        expect_packet("t6a", 5'b00001, 0);
        expect_packet("t6b", 5'b00010, 1);
        link.request_vector = 5'b0;
        check_eq("t6_credit", 32'(link.credit_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/link_scheduler.md
Name: link_scheduler

Overview:
- Output-link scheduler for one router output channel.
- Arbitrates the five input requesters (XPOS, XNEG, YPOS, YNEG, PE) with a round-robin policy.
- Holds the grant for a whole 5-flit packet and enforces credit-based flow control against the downstream receiver, whose credit_out returns one credit per consumed packet.

Parameters:
- CREDITS, 4: downstream buffer capacity in packets; also the reset value of the credit counter.
- FLITS, 5: flits per packet; the grant is held for exactly this many cycles.
- CNT_W, 3: width of the credit and flit counters; must hold max(CREDITS, FLITS-1).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- request_vector  input  5  per-port packet request; bit0=XPOS, 1=XNEG, 2=YPOS, 3=YNEG, 4=PE. Level-sensitive, held by requester until granted.
- credit_in  input  1  one-cycle pulse from downstream; returns one packet credit.
- grant_vector  output  5  one-hot grant; all zero when no packet is in flight.
- flit_valid  output  1  high on every cycle a granted flit crosses the link.
- packet_done  output  1  one-cycle pulse on the last flit of a packet.
- credit_count  output  CNT_W  credits currently available.
- credit_overflow  output  1  sticky error flag: credit returned while counter already at CREDITS.

Behaviour:
Reset (asynchronous, takes effect immediately):
- grant_vector=0, flit_valid=0, packet_done=0, credit_overflow=0.
- credit_count=CREDITS, flit counter=0, priority pointer=0 (XPOS highest), state=IDLE.
- Reset asserted mid-packet aborts the packet: grant drops with no packet_done, and credits are restored to CREDITS.

IDLE state:
- At posedge, if request_vector!=0 and credit_count>0:
  - Select the first set bit scanning from the pointer upward, wrapping 4->0.
  - Register the one-hot grant, load the flit counter to 0, and go to ACTIVE.
- Otherwise remain in IDLE with grant_vector=0.
- Latency: a request visible before edge N produces a grant in the cycle after edge N (1 cycle).

ACTIVE state:
- grant_vector and flit_valid are held high for exactly FLITS consecutive cycles.
- The flit counter increments each cycle.
- packet_done=1 during the cycle in which the counter = FLITS-1.
- At the edge ending that cycle:
  - grant_vector clears and state returns to IDLE.
  - pointer = (winner index + 1) mod 5.
- There is always one IDLE cycle between consecutive packets (link gap of 1 cycle).
- Request changes during ACTIVE are ignored. Deassertion of the granted request does not shorten the packet.

Credit arithmetic:
- One credit is consumed at the IDLE->ACTIVE edge.
- credit_in adds one credit at the next edge.
- Consume and credit_in on the same edge: net change 0.
- credit_in with credit_count=CREDITS and no simultaneous consume: count is unchanged (saturates) and credit_overflow is set; it clears only on reset.
- credit_count=0: no grant is issued regardless of requests. Arbitration resumes on the edge following the credit_in edge.

Arbitration fairness:
- Any continuously requesting port is granted within 5 packets.

Test Plan:
- Reset, then request_vector=5'b00001 held -> grant_vector=00001 one cycle after the first edge; flit_valid high for 5 cycles; packet_done on cycle 5; credit_count 4->3.
- request_vector=5'b10101 held, credit_in pulsed after every packet -> grant order XPOS(0), YPOS(2), PE(4), XPOS(0); 1 idle cycle between packets; credit_count returns to 4 after the final credit.
- request_vector=5'b11111 with no credit_in -> exactly 4 packets granted (ports 0,1,2,3), then credit_count=0 and grant_vector stays 0. A single credit_in pulse -> port 4 is granted on the following cycle.
- credit_in pulsed on the same edge as a new grant with credit_count=2 -> credit_count stays 2. credit_in with credit_count=4 while IDLE -> credit_count stays 4 and credit_overflow=1 thereafter.
- reset asserted during flit 3 of a packet -> grant_vector, flit_valid, packet_done =0 immediately with no packet_done pulse; credit_count=4 and pointer=0. After release with request_vector=5'b00010 -> XNEG is granted.
- Granted port deasserts its request after flit 1 -> grant is still held for all 5 flits; the next arbitration excludes that port.
